math_seq: RTL and testbench



---
 rtl/math_seq.sv | 192 +++++++++++++++++++
 tb/tb_math_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/math_seq.sv
// math_seq: command sequencer in front of the byte-serial `math` accumulator.
// Turns word-wide host commands (LOAD / READ / ADD8 / CLEAR) into the opcode
// stream `math` consumes, and rebuilds full-width words from its 8-bit result.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_op, cmd_data     0=LOAD 1=READ 2=ADD8 3=CLEAR, payload
//   rsp_valid/rsp_ready  READ result handshake
//   rsp_data             READ result word
//   m_op, m_data         registered opcode/operand to math op_in/data_in
//   m_result             math data_out (accumulator low byte)
module math_seq #(
    parameter int unsigned BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [BITS-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [BITS-1:0] rsp_data,
    output logic [7:0]      m_op,
    output logic [7:0]      m_data,
    input  logic [7:0]      m_result
);

    localparam int unsigned BYTES = BITS / 8;
    localparam int unsigned CNT_W = $clog2(BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

    localparam logic [1:0] CMD_LOAD  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_ADD8  = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_CLR = 8'h01;
    localparam logic [7:0] OP_SET = 8'h02;
    localparam logic [7:0] OP_ADD = 8'h03;
    localparam logic [7:0] OP_SHL = 8'h04;
    localparam logic [7:0] OP_SHR = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHL,
        S_SET,
        S_RD,
        S_RSP,
        S_ADD
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_kind;
    logic [BITS-1:0]   r_load;
    logic [7:0]        r_op;
    logic [7:0]        r_data;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [BITS-1:0]   r_rsp_data;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [7:0]        w_op_nxt;
    logic [7:0]        w_data_nxt;
    logic              w_accept;
    logic [BITS-1:0]   w_src;

    // Reload source: a READ restores the word it just shifted out.
    assign w_src = (r_kind == CMD_READ) ? r_rsp_data : r_load;

    // Next state plus the math-side operation for the cycle that state occupies.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = OP_NOP;
        w_data_nxt  = 8'h00;
        w_accept    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    case (cmd_op)
                        CMD_READ: begin
                            w_state_nxt = S_RD;
                            w_cnt_nxt   = CNT_LAST;
                        end
                        CMD_ADD8: w_state_nxt = S_ADD;
                        default:  w_state_nxt = S_CLR;
                    endcase
                end
            end
            S_CLR: begin
                if (r_kind == CMD_CLEAR) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SHL;
                    w_cnt_nxt   = CNT_LAST;
                end
            end
            S_SHL: w_state_nxt = S_SET;
            S_SET: begin
                if (r_cnt == '0) begin
                    w_state_nxt = (r_kind == CMD_READ) ? S_RSP : S_IDLE;
                end else begin
                    w_state_nxt = S_SHL;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_RD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_CLR;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADD:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_CLR: w_op_nxt = OP_CLR;
            S_SHL: begin
                w_op_nxt   = OP_SHL;
                w_data_nxt = 8'd8;
            end
            S_SET: begin
                w_op_nxt   = OP_SET;
                w_data_nxt = 8'(w_src >> {w_cnt_nxt, 3'b000});
            end
            S_RD: begin
                w_op_nxt   = OP_SHR;
                w_data_nxt = 8'd8;
            end
            S_ADD: begin
                w_op_nxt   = OP_ADD;
                w_data_nxt = cmd_data[7:0];
            end
            default: begin
                w_op_nxt   = OP_NOP;
                w_data_nxt = 8'h00;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_kind      <= CMD_LOAD;
            r_load      <= '0;
            r_op        <= OP_NOP;
            r_data      <= 8'h00;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_data      <= w_data_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_RSP);
            if (w_accept) begin
                r_kind <= cmd_op;
                r_load <= cmd_data;
            end
            // m_result still shows the pre-shift low byte at the closing edge.
            if (r_state == S_RD) begin
                r_rsp_data <= {m_result, r_rsp_data[BITS-1:8]};
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign m_op      = r_op;
    assign m_data    = r_data;

endmodule

// File: tb/tb_math_seq.sv
// Bench for math_seq with a behavioural stand-in for the downstream math
// accumulator and a word-level reference of the accumulator contents.
module tb_math_seq;

    localparam logic [1:0] C_LOAD  = 2'd0;
    localparam logic [1:0] C_READ  = 2'd1;
    localparam logic [1:0] C_ADD8  = 2'd2;
    localparam logic [1:0] C_CLEAR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [63:0] cmd_data = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [7:0]  m_op;
    logic [7:0]  m_data;
    logic [7:0]  m_result;

    logic [63:0] m_acc = 64'd0;
    logic [63:0] ref_acc = 64'd0;
    int          checks = 0;
    int          errors = 0;

    math_seq #(.BITS(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .m_op     (m_op),
        .m_data   (m_data),
        .m_result (m_result)
    );

    always #5 clk = ~clk;

    // Downstream accumulator: synchronous reset, byte-wide ops.
    always @(posedge clk) begin
        if (!rst_n) m_acc <= 64'd0;
        else begin
            case (m_op)
                8'h01: m_acc <= 64'd0;
                8'h02: m_acc[7:0] <= m_data;
                8'h03: m_acc <= m_acc + 64'(m_data);
                8'h04: m_acc <= m_acc << m_data;
                8'h05: m_acc <= m_acc >> m_data;
                default: ;
            endcase
        end
    end
    assign m_result = m_acc[7:0];

    // Offer a command from a negedge; returns at the negedge of cycle 1.
    task automatic send_cmd(input logic [1:0] op, input logic [63:0] d, output int waited);
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready stuck at %b, required 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data = {$urandom, $urandom};
        case (op)
            C_LOAD:  ref_acc = d;
            C_ADD8:  ref_acc = ref_acc + 64'(d[7:0]);
            C_CLEAR: ref_acc = 64'd0;
            default: ;
        endcase
    endtask

    // Wait for the READ response (starting at cycle 1) and complete the handshake.
    task automatic do_read(input bit early_ready, output logic [63:0] val, output int lat);
        lat = 1;
        if (early_ready) rsp_ready = 1'b1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        val = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        checks++; if (m_op !== 8'h00) begin errors++; $display("FAIL reset_m_op: got %h required 00", m_op); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h required 00", m_data); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_data !== 64'd0) begin errors++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    endtask

    task automatic test_load_read();
        logic [63:0] v;
        logic [63:0] got;
        logic [7:0]  exp_op [1:18];
        logic [7:0]  exp_dat [1:18];
        int w;
        int lat;
        v = 64'h0123456789ABCDEF;
        exp_op[1] = 8'h01; exp_dat[1] = 8'h00;
        for (int j = 0; j < 8; j++) begin
            exp_op[2 + 2*j] = 8'h04; exp_dat[2 + 2*j] = 8'd8;
            exp_op[3 + 2*j] = 8'h02; exp_dat[3 + 2*j] = v[8*(7-j) +: 8];
        end
        exp_op[18] = 8'h00; exp_dat[18] = 8'h00;
        send_cmd(C_LOAD, v, w);
        for (int k = 1; k <= 18; k++) begin
            checks++;
            if (m_op !== exp_op[k] || (k > 1 && m_data !== exp_dat[k])) begin
                errors++;
                $display("FAIL load_seq cycle %0d: got op %h data %h required op %h data %h", k, m_op, m_data, exp_op[k], exp_dat[k]);
            end
            if (k < 18) @(negedge clk);
        end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL load_done_ready: got %b required 1", cmd_ready); end
        send_cmd(C_READ, 64'd0, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL load_read_b2b: waited %0d required 0", w); end
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if ((k <= 8 && (m_op !== 8'h05 || m_data !== 8'd8)) || (k == 9 && m_op !== 8'h01)) begin
                errors++;
                $display("FAIL read_seq cycle %0d: got op %h data %h", k, m_op, m_data);
            end
            @(negedge clk);
        end
        do_read(1'b0, got, lat);
        lat = lat + 9;
        checks++; if (lat !== 26) begin errors++; $display("FAIL read_latency: got %0d required 26", lat); end
        checks++; if (got !== v) begin errors++; $display("FAIL read1_data: got %h required %h", got, v); end
        send_cmd(C_READ, 64'd0, w);
        do_read(1'b0, got, lat);
        checks++; if (lat !== 26) begin errors++; $display("FAIL read2_latency: got %0d required 26", lat); end
        checks++; if (got !== v) begin errors++; $display("FAIL read2_restore: got %h required %h", got, v); end
    endtask

    task automatic test_carry();
        logic [63:0] got;
        int w;
        int lat;
        send_cmd(C_LOAD, 64'h00000000000000FF, w);
        send_cmd(C_ADD8, 64'hABCDEF0000000001, w);
        checks++; if (m_op !== 8'h03 || m_data !== 8'h01) begin errors++; $display("FAIL add_op: got op %h data %h required 03 01", m_op, m_data); end
        send_cmd(C_READ, 64'd0, w);
        do_read(1'b1, got, lat);
        checks++; if (got !== 64'h0000000000000100) begin errors++; $display("FAIL carry_ff: got %h required 0000000000000100", got); end
        checks++; if (lat !== 26) begin errors++; $display("FAIL carry_latency_early_ready: got %0d required 26", lat); end
        send_cmd(C_LOAD, 64'hFFFFFFFFFFFFFFFF, w);
        send_cmd(C_ADD8, 64'h01, w);
        send_cmd(C_READ, 64'd0, w);
        do_read(1'b0, got, lat);
        checks++; if (got !== 64'd0) begin errors++; $display("FAIL carry_wrap: got %h required 0", got); end
    endtask

    task automatic test_backpressure();
        logic [63:0] v;
        int w;
        int lat;
        v = {$urandom, $urandom};
        send_cmd(C_LOAD, v, w);
        send_cmd(C_READ, 64'd0, w);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 26) begin errors++; $display("FAIL bp_latency: got %0d required 26", lat); end
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== v || cmd_ready !== 1'b0 || m_op !== 8'h00) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid %b data %h ready %b op %h required 1 %h 0 00", s, rsp_valid, rsp_data, cmd_ready, m_op, v);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_sixth: got %b required 1", rsp_valid); end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== v) begin
            errors++;
            $display("FAIL bp_release: valid %b ready %b data %h required 0 1 %h", rsp_valid, cmd_ready, rsp_data, v);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] got;
        int w;
        int lat;
        send_cmd(C_LOAD, 64'h1122334455667788, w);
        repeat (5) @(negedge clk);
        checks++; if (m_op !== 8'h04) begin errors++; $display("FAIL rst_precheck: got op %h required 04", m_op); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_op !== 8'h00 || m_data !== 8'h00 || rsp_valid !== 1'b0 || rsp_data !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: op %h data %h valid %b rsp %h required 00 00 0 0", m_op, m_data, rsp_valid, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || m_op !== 8'h00) begin errors++; $display("FAIL post_reset: ready %b op %h required 1 00", cmd_ready, m_op); end
        send_cmd(C_CLEAR, 64'hDEAD, w);
        checks++; if (m_op !== 8'h01) begin errors++; $display("FAIL clear_op: got %h required 01", m_op); end
        send_cmd(C_READ, 64'd0, w);
        do_read(1'b0, got, lat);
        checks++; if (got !== 64'd0) begin errors++; $display("FAIL clear_read: got %h required 0", got); end
    endtask

    task automatic test_held_cmd();
        logic [63:0] v;
        logic [63:0] got;
        int w;
        int n;
        int adds;
        int lat;
        v = {$urandom, $urandom};
        send_cmd(C_LOAD, v, w);
        cmd_op = C_ADD8;
        cmd_data = 64'h05;
        cmd_valid = 1'b1;
        n = 1;
        adds = 0;
        while (cmd_ready !== 1'b1 && n < 60) begin
            if (m_op === 8'h03) adds++;
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 18) begin errors++; $display("FAIL held_accept_cycle: got %0d required 18", n); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data = 64'hFFFFFFFFFFFFFFFF;
        checks++; if (m_op !== 8'h03 || m_data !== 8'h05) begin errors++; $display("FAIL held_add_op: got op %h data %h required 03 05", m_op, m_data); end
        for (int k = 0; k < 4; k++) begin
            if (m_op === 8'h03) adds++;
            @(negedge clk);
        end
        checks++; if (adds !== 1) begin errors++; $display("FAIL held_accept_count: got %0d required 1", adds); end
        ref_acc = v + 64'd5;
        send_cmd(C_READ, 64'd0, w);
        do_read(1'b0, got, lat);
        checks++; if (got !== ref_acc) begin errors++; $display("FAIL held_result: got %h required %h", got, ref_acc); end
    endtask

    task automatic test_back_to_back();
        int w;
        send_cmd(C_ADD8, 64'h10, w);
        send_cmd(C_ADD8, 64'h22, w);
        checks++; if (w !== 1) begin errors++; $display("FAIL b2b_wait: got %0d required 1", w); end
        checks++; if (m_op !== 8'h03 || m_data !== 8'h22) begin errors++; $display("FAIL b2b_op: got op %h data %h required 03 22", m_op, m_data); end
        send_cmd(C_CLEAR, 64'd0, w);
        checks++; if (w !== 1) begin errors++; $display("FAIL b2b_clear_wait: got %0d required 1", w); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [63:0] d;
        logic [63:0] got;
        logic [63:0] expv;
        int w;
        int lat;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            d = {$urandom, $urandom};
            expv = ref_acc;
            send_cmd(op, d, w);
            if (op == C_READ) begin
                do_read(1'($urandom_range(0, 1)), got, lat);
                checks++;
                if (got !== expv || lat !== 26) begin
                    errors++;
                    $display("FAIL random_read %0d: got %h lat %0d required %h lat 26", i, got, lat, expv);
                end
            end
        end
        send_cmd(C_READ, 64'd0, w);
        expv = ref_acc;
        do_read(1'b0, got, lat);
        checks++; if (got !== expv) begin errors++; $display("FAIL random_final: got %h required %h", got, expv); end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_carry();
        test_backpressure();
        test_async_reset();
        test_held_cmd();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
